// File: rtl/vga_top.sv
// 640x480@60 VGA timing generator with a 4x4 2048-style tile board.
// Colour is 8-bit RRRGGGBB; sync and colour are registered together.
module vga_top (
   input  logic       clk,
   input  logic       clr,
   output logic [2:0] red,
   output logic [2:0] grn,
   output logic [1:0] blu,
   output logic       hsync,
   output logic       vsync
);

   localparam logic [7:0] GAP_RGB = 8'b100_011_01;
   localparam logic [7:0] OFF_RGB = 8'b110_110_10;

   logic [1:0] div_q, div_d;
   logic       pe;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [3:0] cell_q [16];
   logic [3:0] cell_d [16];
   logic [2:0] red_q, red_d;
   logic [2:0] grn_q, grn_d;
   logic [1:0] blu_q, blu_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;

   logic       visible;
   logic       on_board;
   logic       col_hit, row_hit;
   logic [1:0] col, row;
   logic [3:0] tile_exp;
   logic [7:0] rgb;

   function automatic logic [7:0] lut(input logic [3:0] e);
      logic [7:0] c;
      case (e)
         4'd0:    c = 8'b101_101_10;
         4'd1:    c = 8'b111_111_10;
         4'd2:    c = 8'b111_110_01;
         4'd3:    c = 8'b111_100_00;
         4'd4:    c = 8'b111_011_00;
         4'd5:    c = 8'b111_010_00;
         4'd6:    c = 8'b111_001_00;
         4'd7:    c = 8'b111_110_00;
         4'd8:    c = 8'b110_110_00;
         4'd9:    c = 8'b101_101_00;
         4'd10:   c = 8'b100_100_00;
         4'd11:   c = 8'b111_111_00;
         default: c = 8'b000_000_00;
      endcase
      return c;
   endfunction

   // Pixel-enable divider and the 800x525 raster counters
   always_comb begin
      div_d  = div_q + 2'd1;
      pe     = (div_q == 2'd3);
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pe) begin
         if (hcnt_q == 10'd799) begin
            hcnt_d = 10'd0;
            if (vcnt_q == 10'd524) vcnt_d = 10'd0;
            else                   vcnt_d = vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
      cell_d = cell_q;
   end

   // Map the current raster position to sync levels and a colour
   always_comb begin
      visible  = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
      on_board = (hcnt_q >= 10'd100) && (hcnt_q <= 10'd539) &&
                 (vcnt_q >= 10'd20)  && (vcnt_q <= 10'd459);
      col_hit  = 1'b0;
      row_hit  = 1'b0;
      col      = 2'd0;
      row      = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (hcnt_q >= 10'(108 + 108 * c) &&
             hcnt_q <= 10'(207 + 108 * c)) begin
            col_hit = 1'b1;
            col     = 2'(c);
         end
         if (vcnt_q >= 10'(28 + 108 * c) &&
             vcnt_q <= 10'(127 + 108 * c)) begin
            row_hit = 1'b1;
            row     = 2'(c);
         end
      end
      tile_exp = cell_q[{row, col}];
      if (!visible)                rgb = 8'd0;
      else if (col_hit && row_hit) rgb = lut(tile_exp);
      else if (on_board)           rgb = GAP_RGB;
      else                         rgb = OFF_RGB;
      {red_d, grn_d, blu_d} = rgb;
      hsync_d = !((hcnt_q >= 10'd656) && (hcnt_q <= 10'd751));
      vsync_d = !((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491));
   end

   // State and output registers; reset loads the demo board
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         div_q   <= 2'd0;
         hcnt_q  <= 10'd0;
         vcnt_q  <= 10'd0;
         red_q   <= 3'd0;
         grn_q   <= 3'd0;
         blu_q   <= 2'd0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         for (int i = 0; i < 16; i++) cell_q[i] <= 4'(i % 12);
      end else begin
         div_q   <= div_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         blu_q   <= blu_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         cell_q  <= cell_d;
      end
   end

   assign red   = red_q;
   assign grn   = grn_q;
   assign blu   = blu_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_top.sv
// Testbench for vga_top: raster model driven by clock count since reset,
// with vertical jumps applied to the DUT line counter to reach deep rows.
module tb_vga_top;

   localparam int FR = 420000;
   localparam logic [7:0] GAP = 8'b100_011_01;
   localparam logic [7:0] OFF = 8'b110_110_10;
   localparam logic [7:0] LUT [16] = '{
      8'b101_101_10, 8'b111_111_10, 8'b111_110_01, 8'b111_100_00,
      8'b111_011_00, 8'b111_010_00, 8'b111_001_00, 8'b111_110_00,
      8'b110_110_00, 8'b101_101_00, 8'b100_100_00, 8'b111_111_00,
      8'd0, 8'd0, 8'd0, 8'd0};

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [2:0] red, grn;
   logic [1:0] blu;
   logic       hsync, vsync;

   int     tests = 0;
   int     fails = 0;
   longint n = 0;
   longint off = 0;

   vga_top dut (
      .clk   (clk),
      .clr   (clr),
      .red   (red),
      .grn   (grn),
      .blu   (blu),
      .hsync (hsync),
      .vsync (vsync)
   );

   always #5 clk = ~clk;

   // clk edges since reset release
   always @(posedge clk or negedge clr) begin
      if (!clr) n <= 0;
      else      n <= n + 1;
   end

   // raster pixel index of the counter state after edge k
   function automatic int pix(longint k);
      longint p;
      p = (k / 4 + off) % FR;
      if (p < 0) p += FR;
      return int'(p);
   endfunction

   // expected {hsync, vsync, rgb} for a raster pixel index
   function automatic logic [9:0] ref_out(int p);
      int x, y, xo, yo, c, r;
      logic [7:0] rgb;
      logic hs, vs;
      x  = p % 800;
      y  = p / 800;
      hs = !(x >= 656 && x <= 751);
      vs = !(y >= 490 && y <= 491);
      if (x >= 640 || y >= 480) rgb = 8'd0;
      else if (x >= 100 && x <= 539 && y >= 20 && y <= 459) begin
         xo = x - 108;
         yo = y - 28;
         if (xo >= 0 && yo >= 0 && xo % 108 < 100 && yo % 108 < 100 &&
             xo / 108 < 4 && yo / 108 < 4) begin
            c   = xo / 108;
            r   = yo / 108;
            rgb = LUT[(4 * r + c) % 12];
         end else rgb = GAP;
      end else rgb = OFF;
      return {hs, vs, rgb};
   endfunction

   task automatic step();
      logic [9:0] obs, exp;
      int p;
      @(negedge clk);
      obs = {hsync, vsync, red, grn, blu};
      exp = ref_out(pix(n - 1));
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL out n=%0d obs=%b exp=%b", n, obs, exp);
      end
      p = pix(n);
      tests++;
      assert ({dut.vcnt_q, dut.hcnt_q} === {10'(p / 800), 10'(p % 800)})
      else begin
         fails++;
         $error("FAIL cnt n=%0d obs=%0d,%0d exp=%0d,%0d", n,
                dut.hcnt_q, dut.vcnt_q, p % 800, p / 800);
      end
   endtask

   task automatic jump_v(int v);
      int cv;
      cv = pix(n) / 800;
      force dut.vcnt_q = 10'(v);
      #1 release dut.vcnt_q;
      off += longint'(v - cv) * 800;
   endtask

   task automatic seek(int x, int y, logic [7:0] want, string tag);
      int h;
      bit hit;
      hit = 1'b0;
      h = pix(n) % 800;
      jump_v(h < x - 1 ? y : (y + 524) % 525);
      for (int i = 0; i < 3300 && !hit; i++) begin
         step();
         if (pix(n - 1) == y * 800 + x) hit = 1'b1;
      end
      tests++;
      assert (hit && {red, grn, blu} === want) else begin
         fails++;
         $error("FAIL %s rgb=%b want=%b reached=%0d", tag,
                {red, grn, blu}, want, hit);
      end
   endtask

   initial begin
      longint hf[$], hr[$];
      longint vf, vr;
      int hs_in_v;
      bit prev, prev_v, hit;
      int x, y;

      // reset held for the first 20 ns
      @(negedge clk);
      tests++;
      assert ({hsync, vsync, red, grn, blu} === 10'b11_000_000_00) else begin
         fails++;
         $error("FAIL reset_out obs=%b exp=%b",
                {hsync, vsync, red, grn, blu}, 10'b11_000_000_00);
      end
      @(negedge clk);
      clr = 1'b1;

      step();
      tests++;
      assert ({red, grn, blu} === ref_out(0)[7:0]) else begin
         fails++;
         $error("FAIL first_pix obs=%b exp=%b", {red, grn, blu}, OFF);
      end
      step();
      step();
      tests++;
      assert (dut.hcnt_q === 10'd0) else begin
         fails++;
         $error("FAIL hcnt_e3 obs=%0d exp=0", dut.hcnt_q);
      end
      step();
      tests++;
      assert (dut.hcnt_q === 10'd1) else begin
         fails++;
         $error("FAIL hcnt_e4 obs=%0d exp=1", dut.hcnt_q);
      end

      // three lines of horizontal timing
      prev = hsync;
      for (int i = 0; i < 9500; i++) begin
         step();
         if (prev && !hsync) hf.push_back(n);
         if (!prev && hsync) hr.push_back(n);
         prev = hsync;
      end
      tests++;
      assert (hf.size() == 3 && hr.size() == 3 && hf[0] == 2625) else begin
         fails++;
         $error("FAIL hs_first falls=%0d first=%0d exp=2625",
                hf.size(), hf.size() > 0 ? hf[0] : -1);
      end
      for (int i = 0; i < 3 && i < hf.size() && i < hr.size(); i++) begin
         tests++;
         assert (hr[i] - hf[i] == 384) else begin
            fails++;
            $error("FAIL hs_width obs=%0d exp=384", hr[i] - hf[i]);
         end
         if (i > 0) begin
            tests++;
            assert (hf[i] - hf[i-1] == 3200) else begin
               fails++;
               $error("FAIL hs_period obs=%0d exp=3200", hf[i] - hf[i-1]);
            end
         end
      end

      // directed pixel colours
      seek(150, 70, 8'b101_101_10, "px_150_70");
      seek(250, 70, 8'b111_111_10, "px_250_70");
      seek(250, 180, 8'b111_010_00, "px_250_180");
      seek(104, 70, 8'b100_011_01, "px_104_70");
      seek(50, 200, 8'b110_110_10, "px_50_200");
      seek(700, 200, 8'b000_000_00, "px_700_200");

      // random pixels against the model
      for (int i = 0; i < 4; i++) begin
         x = int'($urandom_range(2, 799));
         y = int'($urandom_range(1, 524));
         seek(x, y, ref_out(y * 800 + x)[7:0], "px_rand");
      end

      // vertical sync pulse
      jump_v(489);
      vf = -1;
      vr = -1;
      hs_in_v = 0;
      prev = hsync;
      prev_v = vsync;
      for (int i = 0; i < 10000 && vr < 0; i++) begin
         step();
         if (prev_v && !vsync) vf = n;
         if (!prev_v && vsync) vr = n;
         if (!vsync && prev && !hsync) hs_in_v++;
         prev = hsync;
         prev_v = vsync;
      end
      tests++;
      assert (vf >= 0 && vr - vf == 6400) else begin
         fails++;
         $error("FAIL vs_width obs=%0d exp=6400", vr - vf);
      end
      tests++;
      assert (hs_in_v == 2) else begin
         fails++;
         $error("FAIL hs_in_vs obs=%0d exp=2", hs_in_v);
      end

      // frame wrap
      jump_v(524);
      hit = 1'b0;
      for (int i = 0; i < 3300 && !hit; i++) begin
         step();
         if (pix(n) == 0 && pix(n - 1) == FR - 1) hit = 1'b1;
      end
      tests++;
      assert (hit && dut.hcnt_q === 10'd0 && dut.vcnt_q === 10'd0) else begin
         fails++;
         $error("FAIL wrap_cnt obs=%0d,%0d exp=0,0 reached=%0d",
                dut.hcnt_q, dut.vcnt_q, hit);
      end
      step();
      tests++;
      assert ({red, grn, blu} === OFF) else begin
         fails++;
         $error("FAIL wrap_pix obs=%b exp=%b", {red, grn, blu}, OFF);
      end

      // asynchronous reset mid-frame
      jump_v(300);
      for (int i = 0; i < 50; i++) step();
      #2 clr = 1'b0;
      #1;
      tests++;
      assert ({hsync, vsync, red, grn, blu} === 10'b11_000_000_00 &&
              dut.hcnt_q === 10'd0 && dut.vcnt_q === 10'd0) else begin
         fails++;
         $error("FAIL mid_reset obs=%b h=%0d v=%0d exp=%b,0,0",
                {hsync, vsync, red, grn, blu}, dut.hcnt_q, dut.vcnt_q,
                10'b11_000_000_00);
      end
      @(negedge clk);
      @(negedge clk);
      off = 0;
      clr = 1'b1;
      for (int i = 0; i < 4; i++) step();
      tests++;
      assert (dut.hcnt_q === 10'd1 && dut.vcnt_q === 10'd0) else begin
         fails++;
         $error("FAIL restart obs=%0d,%0d exp=1,0", dut.hcnt_q, dut.vcnt_q);
      end
      for (int i = 0; i < 40; i++) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_top.md
# vga_top

Top-level VGA display block for the 2048 project. It derives a 25 MHz pixel enable from the 100 MHz system clock and generates 640×480 @ 60 Hz timing with active-low syncs. It renders a 4×4 2048-style tile board in 8-bit RRRGGGBB colour. The board contents come from an internal exponent register loaded with a fixed demo pattern at reset, and the block drives the board's VGA connector pins directly.

## Interface
- No parameters; all timing constants are fixed as listed below.
- clk  input  1  system clock, 100 MHz (10 ns period).
- clr  input  1  reset; one clock; reset is asynchronous and active-low.
- red  output  3  red intensity, 0 during blanking.
- grn  output  3  green intensity, 0 during blanking.
- blu  output  2  blue intensity, 0 during blanking.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.

## Operation
- **Pixel divider:** a 2-bit counter `div` increments every clk. The pixel enable `pe` is 1 when `div==3`, i.e. one clk in four (25 MHz).
- **Horizontal counter** `hcnt` (10 bits) advances on `pe`. It counts 0..799 and wraps to 0.
  - Visible region is 0..639. Front porch is 640..655.
  - Sync is 656..751. Back porch is 752..799.
- **Vertical counter** `vcnt` (10 bits) advances on `pe` when `hcnt==799`. It counts 0..524 and wraps to 0.
  - Visible region is 0..479. Front porch is 480..489.
  - Sync is 490..491. Back porch is 492..524.
- When `hcnt==799` and `vcnt==524` coincide on `pe`, both counters wrap to 0 together.
- **Sync generation:**
  - `hsync` is 0 iff `hcnt` is in 656..751.
  - `vsync` is 0 iff `vcnt` is in 490..491.
- **Board geometry:**
  - The board spans x 100..539 and y 20..459.
  - Tile (row r, col c), r,c ∈ 0..3, spans x 108+108c .. 207+108c and y 28+108r .. 127+108r.
  - The remaining board pixels are gaps.
- **Board state:**
  - 16 cells, row-major index i = 4r+c, each holding a 4-bit exponent (0 means empty).
  - At reset, cell i is loaded with i mod 12.
  - The cells stay constant afterwards; no inputs modify them.
- **Colour LUT** (red, grn, blu) by exponent:
  - 0: 101,101,10
  - 1: 111,111,10
  - 2: 111,110,01
  - 3: 111,100,00
  - 4: 111,011,00
  - 5: 111,010,00
  - 6: 111,001,00
  - 7: 111,110,00
  - 8: 110,110,00
  - 9: 101,101,00
  - 10: 100,100,00
  - 11: 111,111,00
  - Exponents 12..15 map to 000,000,00.
- **Pixel colour priority:**
  1. Outside the visible region: 000,000,00.
  2. Tile pixel: LUT colour of that cell's exponent.
  3. Board gap: 100,011,01.
  4. Visible pixel off the board: 110,110,10.

## Timing
- **Reset (clr=0):** `div`, `hcnt` and `vcnt` are 0; hsync=1, vsync=1; red, grn and blu are 0; the board is loaded with the demo pattern.
  - Reset acts immediately, including mid-line or mid-frame.
- **After clr rises:** `pe` first asserts on the 4th rising clk edge. `hcnt` becomes 1 on the next edge after that pe.
- **Output register:** all five outputs are registered functions of (`hcnt`, `vcnt`) with exactly 1 clk latency. Sync and colour stay mutually aligned.
- **Period figures:**
  - Line period is 800×4 = 3200 clk (32 µs).
  - hsync low width is 384 clk.
  - Frame period is 525 lines = 1,680,000 clk (16.8 ms).
  - vsync low width is 6400 clk.

## Test plan
- **Reset values:** clr=0 for 20 ns, then 1 → during reset hsync=1, vsync=1, RGB=0. The first `hcnt` increment occurs 4 clk after release.
- **Horizontal timing:** run 3 lines → hsync falling edges are 3200 clk apart and each low pulse lasts 384 clk. The first fall occurs when `hcnt` reaches 656.
- **Vertical timing:** run 2 frames → vsync falls every 1,680,000 clk with a low width of 6400 clk. hsync keeps toggling during vsync.
- **Pixel colours:**
  - (x=150,y=70) → 101,101,10 (cell 0 is empty).
  - (250,70) → 111,111,10.
  - (250,180) → 111,010,00 (cell 5).
  - (104,70) → 100,011,01 (gap).
  - (50,200) → 110,110,10 (off the board).
  - (700,200) → 000,000,00 (blanking).
- **Wrap-around:** at `hcnt=799`, `vcnt=524`, pe → both counters read 0 on the next clk, and the next frame's first pixel colour matches the first frame's.
- **Reset mid-frame:** assert clr=0 while `vcnt≈300` → outputs go to reset values asynchronously. After release, timing restarts from (0,0).
